// File: rtl/muldiv_pkg.sv
// Shared op encodings and FSM states for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring subtract for divide.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] qr,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] qr_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] sub;
    logic             ge;

    always_comb begin
        sum    = {1'b0, acc} + (qr[0] ? {1'b0, opnd} : '0);
        rem_sh = {acc, qr[WIDTH-1]};
        ge     = rem_sh >= {1'b0, opnd};
        // rem_sh < 2*opnd, so the difference always fits in WIDTH bits
        sub    = rem_sh[WIDTH-1:0] - opnd;
        if (div) begin
            acc_next = ge ? sub : rem_sh[WIDTH-1:0];
            qr_next  = {qr[WIDTH-2:0], ge};
        end else begin
            acc_next = sum[WIDTH:1];
            qr_next  = {sum[0], qr[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit writing HI/LO with a start/busy/done handshake.
// Optional macro MULDIV_DIV0_FLAG_EN adds a registered div_zero output.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
`ifdef MULDIV_DIV0_FLAG_EN
    ,
    output logic             div_zero
`endif
);

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             is_div;
    logic             neg_lo;
    logic             neg_hi;
    logic             b_zero;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] qr;
    logic [WIDTH-1:0] acc_nx;
    logic [WIDTH-1:0] qr_nx;

    logic             signed_op;
    logic             sa;
    logic             sb;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;

    assign last = cnt == CNT_W'(WIDTH - 1);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = state != IDLE;
    end

    // Operand capture: signed ops iterate on magnitudes, signs are reapplied in FIX
    always_comb begin
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        sa        = signed_op & srca[WIDTH-1];
        sb        = signed_op & srcb[WIDTH-1];
        mag_a     = sa ? -srca : srca;
        mag_b     = sb ? -srcb : srcb;
    end

    muldiv_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .div     (is_div),
        .acc     (acc),
        .qr      (qr),
        .opnd    (opnd),
        .acc_next(acc_nx),
        .qr_next (qr_nx)
    );

    always_comb begin
        prod     = {acc, qr};
        prod_fix = neg_lo ? -prod : prod;
        q_fix    = b_zero ? '1 : (neg_lo ? -qr : qr);
        r_fix    = neg_hi ? -acc : acc;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            is_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            b_zero <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
            qr     <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt    <= '0;
                        is_div <= op[1];
                        neg_lo <= sa ^ sb;
                        neg_hi <= sa;
                        b_zero <= srcb == '0;
                        opnd   <= op[1] ? mag_b : mag_a;
                        acc    <= '0;
                        qr     <= op[1] ? mag_a : mag_b;
                    end
                end
                RUN: begin
                    acc <= acc_nx;
                    qr  <= qr_nx;
                    cnt <= last ? '0 : cnt + 1'b1;
                end
                FIX: begin
                    done <= 1'b1;
                    if (is_div) begin
                        hi <= r_fix;
                        lo <= q_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MULDIV_DIV0_FLAG_EN
    always_ff @(posedge clk) begin
        if (!rst_n)            div_zero <= 1'b0;
        else if (state == FIX) div_zero <= is_div & b_zero;
    end
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: random and directed ops against an arithmetic model.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] srca = '0;
    logic [W-1:0] srcb = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
`ifdef MULDIV_DIV0_FLAG_EN
    logic         div_zero;
`endif

    int passed = 0;
    int total = 0;
    int cyc = 0;
    int start_cyc = 0;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .op   (op),
        .srca (srca),
        .srcb (srcb),
        .busy (busy),
        .done (done),
        .hi   (hi),
        .lo   (lo)
`ifdef MULDIV_DIV0_FLAG_EN
        ,
        .div_zero(div_zero)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic exp_t model(input logic [1:0] o,
                                   input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t        e;
        logic [63:0] p;
        longint      sp;
        int          q;
        int          r;
        e.dz = 1'b0;
        case (o)
            OP_MULT: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                p  = sp;
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            OP_MULTU: begin
                p  = {32'h0, a} * {32'h0, b};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            default: begin
                if (b == 0) begin
                    e.dz = 1'b1;
                    e.lo = '1;
                    e.hi = a;
                end else if (o == OP_DIVU) begin
                    e.lo = a / b;
                    e.hi = a % b;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.lo = 32'h8000_0000;
                    e.hi = '0;
                end else begin
                    q = $signed(a) / $signed(b);
                    r = $signed(a) % $signed(b);
                    e.lo = q;
                    e.hi = r;
                end
            end
        endcase
        return e;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return W'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Caller is at a negedge; start is held for exactly one posedge
    task automatic issue(input logic [1:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        op    = o;
        srca  = a;
        srcb  = b;
        start = 1'b1;
        sbq.push_back(model(o, a, b));
        @(posedge clk);
        #1;
        start_cyc = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit           got = 0;
        bit           busy_ok = 1;
        bit           hold_ok = 1;
        logic [W-1:0] hi0 = hi;
        logic [W-1:0] lo0 = lo;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                chk("latency", 64'(cyc - start_cyc), 64'(W + 1));
                chk("busy_in_done", 64'(busy), 64'd0);
            end else begin
                if (!busy) busy_ok = 0;
                if (hi !== hi0 || lo !== lo0) hold_ok = 0;
            end
        end
        chk("done_seen", 64'(got), 64'd1);
        chk("busy_while_running", 64'(busy_ok), 64'd1);
        chk("hilo_hold", 64'(hold_ok), 64'd1);
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (sbq.size() == 0) begin
                total++;
                $display("FAIL unexpected_done: hi=%h lo=%h", hi, lo);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("hi", 64'(hi), 64'(e.hi));
                chk("lo", 64'(lo), 64'(e.lo));
`ifdef MULDIV_DIV0_FLAG_EN
                chk("div_zero", 64'(div_zero), 64'(e.dz));
`endif
            end
        end
    end

    initial begin
        bit saw;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done();
        issue(OP_MULT,  -32'sd3, 32'd7);               wait_done();
        issue(OP_MULT,  32'h8000_0000, 32'h8000_0000); wait_done();
        issue(OP_DIV,   -32'sd7, 32'd2);               wait_done();
        issue(OP_DIVU,  32'd100, 32'd7);               wait_done();
        issue(OP_DIVU,  32'd100, 32'd0);               wait_done();
        issue(OP_DIV,   -32'sd5, 32'd0);               wait_done();
        issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF); wait_done();
        issue(OP_DIV,   32'h8000_0000, 32'd3);         wait_done();

        // second start at E5 while busy must be dropped
        @(negedge clk);
        issue(OP_MULTU, 32'd12345, 32'd678);
        repeat (4) @(posedge clk);
        #1;
        op = OP_DIVU; srca = 32'd9; srcb = 32'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();
        issue(OP_DIVU, 32'd9, 32'd3); wait_done();

        // reset mid-RUN aborts with no done pulse
        @(negedge clk);
        issue(OP_MULT, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sbq.delete();
        @(posedge clk);
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        rst_n = 1'b1;
        saw = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) saw = 1;
        end
        chk("no_done_after_abort", 64'(saw), 64'd0);
        issue(OP_DIV, -32'sd100, 32'd7); wait_done();

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 1)
                repeat ($urandom_range(1, 3)) @(negedge clk);
            issue(2'($urandom_range(0, 3)), pick(), pick());
            wait_done();
        end

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
